// File: rtl/fft_r22sdf_reorder_pkg.sv
// Shared helpers for the R2²SDF output reorder buffer.
// This package provides bit-reversal and ceil(log2) helpers, both usable in elaboration-time expressions.
package fft_r22sdf_reorder_pkg;

  localparam int unsigned BITREV_MAX_W = 16;

  // Reverse the low w bits of v; the result is right-aligned.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int unsigned w);
    logic [BITREV_MAX_W-1:0] r;
    logic [BITREV_MAX_W-1:0] s;
    r = '0;
    s = v;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        r = {r[BITREV_MAX_W-2:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_r22sdf_reorder_ram.sv
// Simple dual-port ping-pong RAM for the reorder buffer.
// The read path has two registers: the synchronous read register and a second output register.
module fft_r22sdf_reorder_ram
  import fft_r22sdf_reorder_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 50
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_p1_q;
  logic [DW-1:0] rd_p2_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rd_p1_q <= mem_q[raddr_i];
    rd_p2_q <= rd_p1_q;
  end

  assign rdata_o = rd_p2_q;

endmodule

// File: rtl/fft_r22sdf_reorder.sv
// Output reorder buffer: writes bit-reversed frames into one RAM bank and reads the other in natural order.
// The first natural-order sample of a frame appears three clocks after the frame's last write.
module fft_r22sdf_reorder
  import fft_r22sdf_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int N_LOG2     = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sof_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_re_i,
  input  logic [DATA_WIDTH-1:0] x_im_i,
  output logic                  valid_o,
  output logic                  sof_o,
  output logic [DATA_WIDTH-1:0] z_re_o,
  output logic [DATA_WIDTH-1:0] z_im_o
);

  localparam int AW = N_LOG2 + 1;
  localparam int WW = 2 * DATA_WIDTH;
  localparam logic [N_LOG2-1:0] LAST = '1;

  logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d, wr_idx;
  logic              wr_bank_q, wr_bank_d;
  logic              synced_q, synced_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_active_q, rd_active_d;
  logic              wr_en, frame_done;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [WW-1:0]     rd_data;
  logic              vld_p1_q, vld_p2_q, sof_p1_q, sof_p2_q;
  logic              valid_q, sof_q;
  logic [DATA_WIDTH-1:0] z_re_q, z_im_q;

  always_comb begin
    wr_en      = valid_i & (synced_q | sof_i);
    wr_idx     = sof_i ? '0 : wr_cnt_q;
    frame_done = wr_en && (wr_idx == LAST);
    wr_addr    = {wr_bank_q, N_LOG2'(bitrev(BITREV_MAX_W'(wr_idx), N_LOG2))};
    rd_addr    = {rd_bank_q, rd_cnt_q};

    synced_d    = synced_q | (valid_i & sof_i);
    wr_cnt_d    = wr_en ? wr_idx + N_LOG2'(1) : wr_cnt_q;
    wr_bank_d   = wr_bank_q ^ frame_done;
    bank_full_d = bank_full_q;
    if (frame_done) bank_full_d[wr_bank_q] = 1'b1;

    // The full flag set this edge is already visible here, so a finishing read
    // can roll straight into the bank that just completed.
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    if (rd_active_q) begin
      if (rd_cnt_q == LAST) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d   = ~rd_bank_q;
        rd_cnt_d    = '0;
        rd_active_d = bank_full_d[~rd_bank_q];
      end else begin
        rd_cnt_d = rd_cnt_q + N_LOG2'(1);
      end
    end else if (bank_full_d[~wr_bank_d]) begin
      rd_active_d = 1'b1;
      rd_bank_d   = ~wr_bank_d;
      rd_cnt_d    = '0;
    end
  end

  fft_r22sdf_reorder_ram #(.AW(AW), .DW(WW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i ({x_re_i, x_im_i}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      synced_q    <= 1'b0;
      bank_full_q <= '0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      sof_p1_q    <= 1'b0;
      sof_p2_q    <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      z_re_q      <= '0;
      z_im_q      <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      synced_q    <= synced_d;
      bank_full_q <= bank_full_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      // p1: RAM read register, p2: RAM output register, then the output stage.
      vld_p1_q    <= rd_active_q;
      sof_p1_q    <= rd_active_q && (rd_cnt_q == '0);
      vld_p2_q    <= vld_p1_q;
      sof_p2_q    <= sof_p1_q;
      valid_q     <= vld_p2_q;
      sof_q       <= sof_p2_q;
      if (vld_p2_q) begin
        z_re_q <= rd_data[WW-1:DATA_WIDTH];
        z_im_q <= rd_data[DATA_WIDTH-1:0];
      end
    end
  end

  assign valid_o = valid_q;
  assign sof_o   = sof_q;
  assign z_re_o  = z_re_q;
  assign z_im_o  = z_im_q;

endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Bench for fft_r22sdf_reorder: directed frames on an N=8 instance, random frames on an N=64 instance.
// Expected outputs come from a frame-level model (natural index k = arrival position bitrev(k)).
module tb_fft_r22sdf_reorder;

  localparam int DW  = 25;
  localparam int NLA = 3;
  localparam int NLB = 6;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sof;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, sof_a = 1'b0, vld_a = 1'b0;
  logic [DW-1:0] xre_a = '0, xim_a = '0;
  logic vo_a, so_a;
  logic [DW-1:0] zre_a, zim_a;

  logic rst_b = 1'b0, sof_b = 1'b0, vld_b = 1'b0;
  logic [DW-1:0] xre_b = '0, xim_b = '0;
  logic vo_b, so_b;
  logic [DW-1:0] zre_b, zim_b;

  fft_r22sdf_reorder #(.DATA_WIDTH(DW), .N_LOG2(NLA)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .sof_i(sof_a), .valid_i(vld_a),
    .x_re_i(xre_a), .x_im_i(xim_a),
    .valid_o(vo_a), .sof_o(so_a), .z_re_o(zre_a), .z_im_o(zim_a)
  );

  fft_r22sdf_reorder #(.DATA_WIDTH(DW), .N_LOG2(NLB)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .sof_i(sof_b), .valid_i(vld_b),
    .x_re_i(xre_b), .x_im_i(xim_b),
    .valid_o(vo_b), .sof_o(so_b), .z_re_o(zre_b), .z_im_o(zim_b)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_n      = 0;
  exp_t q[2][$];
  logic [DW-1:0] fre[2][64];
  logic [DW-1:0] fim[2][64];
  int   wj[2];
  bit   synced[2];
  int   last_end[2];

  function automatic int brev(input int v, input int nl);
    int r = 0;
    for (int i = 0; i < nl; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Frame-level model: buffer a frame in arrival order, release it in natural order when complete.
  task automatic model_step(input int c, input int nl, input logic rst, input logic v,
                            input logic s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    int   n;
    int   start;
    exp_t e;
    n = 1 << nl;
    if (rst) begin
      q[c].delete();
      wj[c] = 0;
      synced[c] = 1'b0;
      last_end[c] = 0;
      return;
    end
    if (!(v && (synced[c] || s))) return;
    if (s) begin
      wj[c] = 0;
      synced[c] = 1'b1;
    end
    fre[c][wj[c]] = re;
    fim[c][wj[c]] = im;
    if (wj[c] == n - 1) begin
      start = (edge_n + 3 > last_end[c] + 1) ? edge_n + 3 : last_end[c] + 1;
      for (int k = 0; k < n; k++) begin
        e.re  = fre[c][brev(k, nl)];
        e.im  = fim[c][brev(k, nl)];
        e.sof = (k == 0);
        e.cyc = start + k;
        q[c].push_back(e);
      end
      last_end[c] = start + n - 1;
      wj[c] = 0;
    end else begin
      wj[c] = wj[c] + 1;
    end
  endtask

  initial begin
    wj = '{0, 0};
    synced = '{1'b0, 1'b0};
    last_end = '{0, 0};
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_a && vld_a && (synced[0] || sof_a) && dut_a.bank_full_q[dut_a.wr_bank_q]) begin
        $display("FAIL overrun_a: write into full bank %0d at cycle %0d, required empty bank",
                 dut_a.wr_bank_q, edge_n);
        miscompares++;
      end
      if (!rst_b && vld_b && (synced[1] || sof_b) && dut_b.bank_full_q[dut_b.wr_bank_q]) begin
        $display("FAIL overrun_b: write into full bank %0d at cycle %0d, required empty bank",
                 dut_b.wr_bank_q, edge_n);
        miscompares++;
      end
      model_step(0, NLA, rst_a, vld_a, sof_a, xre_a, xim_a);
      model_step(1, NLB, rst_b, vld_b, sof_b, xre_b, xim_b);
    end
  end

  task automatic mon(input int c, input logic rst, input logic v, input logic s,
                     input logic [DW-1:0] re, input logic [DW-1:0] im);
    exp_t e;
    if (rst) return;
    if (v) begin
      vectors++;
      if (q[c].size() == 0) begin
        $display("FAIL out%0d_unexpected: valid re=%0h im=%0h at cycle %0d, required no output",
                 c, re, im, edge_n);
        miscompares++;
      end else begin
        e = q[c].pop_front();
        if (re !== e.re || im !== e.im || s !== e.sof || edge_n != e.cyc) begin
          $display("FAIL out%0d_sample: got re=%0h im=%0h sof=%0b cyc=%0d, required re=%0h im=%0h sof=%0b cyc=%0d",
                   c, re, im, s, edge_n, e.re, e.im, e.sof, e.cyc);
          miscompares++;
        end
      end
    end else begin
      if (s !== 1'b0) begin
        $display("FAIL out%0d_sof_idle: got sof=%0b with valid low, required 0", c, s);
        miscompares++;
      end
      if (q[c].size() != 0) begin
        e = q[c][0];
        if (e.cyc <= edge_n) begin
          $display("FAIL out%0d_missing: got no valid at cycle %0d, required re=%0h sof=%0b",
                   c, edge_n, e.re, e.sof);
          miscompares++;
          void'(q[c].pop_front());
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, rst_a, vo_a, so_a, zre_a, zim_a);
    mon(1, rst_b, vo_b, so_b, zre_b, zim_b);
  end

  task automatic drv(input int c, input logic v, input logic s,
                     input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(posedge clk);
    #2;
    if (c == 0) begin
      vld_a = v; sof_a = s; xre_a = re; xim_a = im;
    end else begin
      vld_b = v; sof_b = s; xre_b = re; xim_b = im;
    end
  endtask

  task automatic idle(input int c, input int n);
    for (int i = 0; i < n; i++) drv(c, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    vectors++;
    if (got !== req) begin
      $display("FAIL %s: got %0h, required %0h", name, got, req);
      miscompares++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, DW'(vo_a), '0);
    chk({tag, "_sof"},   DW'(so_a), '0);
    chk({tag, "_zre"},   zre_a, '0);
    chk({tag, "_zim"},   zim_a, '0);
  endtask

  initial begin
    int  b;
    bit  seen;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(0, 3);

    // Single frame: re = bitrev(j), im = -re, natural-order output 0..7.
    for (int j = 0; j < 8; j++)
      drv(0, 1'b1, j == 0, DW'(brev(j, NLA)), DW'(-brev(j, NLA)));
    idle(0, 14);

    // Four back-to-back frames with valid held high.
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < 8; j++)
        drv(0, 1'b1, j == 0, DW'(8 * f + brev(j, NLA)), DW'($urandom));
    idle(0, 16);

    // Valid toggling every other clock: each frame bursts out in 8 clocks.
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 8; j++) begin
        drv(0, 1'b1, j == 0, DW'(40 + 8 * f + brev(j, NLA)), DW'($urandom));
        drv(0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
      end
    idle(0, 16);

    // Partial frame of 5 abandoned by a new sof.
    for (int j = 0; j < 5; j++)
      drv(0, 1'b1, j == 0, DW'(100 + j), DW'(100 + j));
    for (int j = 0; j < 8; j++)
      drv(0, 1'b1, j == 0, DW'(120 + brev(j, NLA)), DW'($urandom));
    idle(0, 16);

    // Reset one clock while a frame is being output, then a fresh frame.
    for (int j = 0; j < 8; j++)
      drv(0, 1'b1, j == 0, DW'(200 + brev(j, NLA)), DW'($urandom));
    idle(0, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (vo_a && zre_a == DW'(203)) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      $display("FAIL midreset_wait: got no index-3 output within 20 clocks, required one");
      miscompares++;
    end
    @(posedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    idle(0, 2);
    for (int j = 0; j < 8; j++)
      drv(0, 1'b1, j == 0, DW'(300 + brev(j, NLA)), DW'(-(300 + brev(j, NLA))));
    idle(0, 16);

    // Random data and random valid gaps on the N=64 instance.
    for (int f = 0; f < 100; f++)
      for (int j = 0; j < 64; j++) begin
        while ($urandom_range(0, 3) == 0)
          drv(1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
        drv(1, 1'b1, j == 0, DW'($urandom), DW'($urandom));
      end
    idle(1, 1);

    b = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && b < 400) begin
      @(posedge clk);
      b++;
    end
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (q[c].size() != 0) begin
        $display("FAIL drain%0d: got %0d outputs still pending, required 0", c, q[c].size());
        miscompares++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
